ser_frame_ctrl: RTL
===================

SER_FRAME_CTRL -- requirements
Module: ser_frame_ctrl

Interface
REQ-001 The block SHALL have one clock `clk`. Reset SHALL be synchronous and active-high on `rst`.
REQ-002 Ports SHALL be as follows; all outputs are registered except `rdy`.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  2  frame request per requester (bit i = requester i)
- vld  in  2  nibble valid per requester
- nib0  in  4  nibble from requester 0
- nib1  in  4  nibble from requester 1
- gnt  out  2  one-hot grant, held for the whole frame
- rdy  out  2  nibble ready; combinational, equal to gnt when state is LOAD, else 0
- ld_en  out  1  one-cycle write strobe to the serializer buffer
- ld_idx  out  4  nibble slot being written, 0..15
- ld_data  out  4  nibble being written
- sh_en  out  1  serial shift enable
- sh_idx  out  6  bit index being shifted, 0..63
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on the last shift cycle

Function
REQ-003 The state machine SHALL have states IDLE, LOAD, SHIFT and, with the gap option, GAP.
REQ-004 Arbitration in IDLE:
- On an edge where req is nonzero, set gnt one-hot and go to LOAD.
- Single request: grant that requester.
- Both requesting: grant the requester named by the round-robin pointer `ptr`.
- After any grant, `ptr` SHALL point to the other requester.
REQ-005 req SHALL be ignored outside IDLE, and deasserting req after the grant SHALL NOT end the frame.
REQ-006 A nibble transfer SHALL occur on an edge where vld[g] and rdy[g] are both high, g being the granted requester.
REQ-007 The cycle after a transfer, ld_en=1, ld_data = the granted requester's nibble, and ld_idx = the load count (0..15). On every other cycle ld_en=0, and ld_idx/ld_data hold their last values.
REQ-008 If vld[g] is low in LOAD, the block SHALL stall indefinitely with no transfer and the load count unchanged.
REQ-009 After the 16th transfer (load count 15), the next state SHALL be SHIFT, with rdy=0, sh_en=1 and sh_idx=0; ld_en=1 for slot 15 in that same cycle.
REQ-010 In SHIFT, sh_en SHALL stay high for exactly 64 consecutive cycles, and sh_idx SHALL increment 0..63 with no stalls.
REQ-011 done SHALL be 1 only in the cycle where sh_idx=63.
REQ-012 After the sh_idx=63 cycle, the block SHALL clear gnt and sh_en and go to IDLE (or to GAP when enabled). sh_idx SHALL wrap to 0.
REQ-013 The load count and sh_idx SHALL be modulo counters (4-bit and 6-bit) that return to 0 at each frame end.
REQ-014 With both vld bits constantly high, frame timing SHALL be:
- grant edge E0;
- transfers on edges E1..E16;
- SHIFT cycles E16..E79;
- IDLE after E80.
REQ-015 A new grant MAY occur on edge E80 when re-entering IDLE. Requests pending during a frame SHALL be arbitrated on the first IDLE edge.

Reset
REQ-016 With rst high on an edge, the block SHALL go to IDLE and set gnt=0, ld_en=0, ld_idx=0, ld_data=0, sh_en=0, sh_idx=0, done=0, busy=0, ptr=0 (requester 0 favoured), load count 0, gap count 0.
REQ-017 Reset SHALL take priority over every other event, including mid-LOAD, mid-SHIFT and a simultaneous req; the aborted frame SHALL NOT raise done.

Configuration
REQ-018 Macro `SER_FRAME_GAP_EN`:
- Defined: after the sh_idx=63 cycle, the block SHALL spend exactly 4 cycles in GAP with busy=1, gnt=0 and rdy=0, then return to IDLE. In the constant-vld case the earliest next grant SHALL be edge E84.
- Undefined: the GAP state and gap counter SHALL NOT exist, and timing SHALL be as in REQ-014.

Verification
REQ-019 Single frame: req=01 at E0, vld=11, nib0 = slot index → gnt=01; ld_en at E1..E16 with ld_idx 0..15 and ld_data 0..15; sh_idx 0..63 over E16..E79; done only at E79; gnt=00 after E80.
REQ-020 Contention: req=11 held continuously → grants 01, 10, 01 on consecutive frames, each new grant at the IDLE-return edge (E80, E160).
REQ-021 Stall: vld[0] low for 5 cycles after transfer 3 → ld_idx stays 3, no ld_en in those cycles, and the first SHIFT cycle is delayed by exactly 5 cycles.
REQ-022 Reset mid-SHIFT at sh_idx=30 → all outputs 0, no done pulse; a subsequent req=11 is granted to requester 0.
REQ-023 With `SER_FRAME_GAP_EN` defined and req=10 held → busy high for E0..E83 and the second grant at E84.
REQ-024 req dropped at E3 → the frame completes normally with done at E79.

Source files
------------

// File: rtl/ser_frame_ctrl.sv
// ============================================================================
// ser_frame_ctrl
// ----------------------------------------------------------------------------
// Two-requester frame controller for a 64-bit serializer.
//
// A granted requester loads 16 nibbles into the serializer buffer. The
// controller then drives 64 consecutive shift cycles. Frames follow this
// sequence:
//   IDLE  -> arbitrate between the two requesters (round robin on contention)
//   LOAD  -> accept 16 nibbles from the granted requester (vld/rdy handshake)
//   SHIFT -> 64 back-to-back shift cycles; done pulses on the last one
//   GAP   -> optional 4-cycle quiet period after SHIFT
//
// Configuration macro:
//   SER_FRAME_GAP_EN  When defined, the GAP state and its counter are built
//                     in. When undefined, they do not exist at all.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   2  frame request per requester
//   vld      in   2  nibble valid per requester
//   nib0     in   4  nibble from requester 0
//   nib1     in   4  nibble from requester 1
//   gnt      out  2  one-hot grant, held for the whole frame (registered)
//   rdy      out  2  nibble ready; equals gnt while loading (combinational)
//   ld_en    out  1  one-cycle buffer write strobe (registered)
//   ld_idx   out  4  buffer slot being written (registered)
//   ld_data  out  4  nibble being written (registered)
//   sh_en    out  1  serial shift enable (registered)
//   sh_idx   out  6  bit index being shifted (registered)
//   busy     out  1  high whenever not IDLE (registered)
//   done     out  1  pulse on the last shift cycle (registered)
// ============================================================================
module ser_frame_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] vld,
    input  logic [3:0] nib0,
    input  logic [3:0] nib1,
    output logic [1:0] gnt,
    output logic [1:0] rdy,
    output logic       ld_en,
    output logic [3:0] ld_idx,
    output logic [3:0] ld_data,
    output logic       sh_en,
    output logic [5:0] sh_idx,
    output logic       busy,
    output logic       done
);

`ifdef SER_FRAME_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;
`endif

    state_t     r_state;
    logic       r_ptr;       // requester favoured on the next contention
    logic [3:0] r_ld_cnt;    // nibble slot for the next transfer
    logic [1:0] r_gnt;
    logic       r_ld_en;
    logic [3:0] r_ld_idx;
    logic [3:0] r_ld_data;
    logic       r_sh_en;
    logic [5:0] r_sh_idx;
    logic       r_busy;
    logic       r_done;
`ifdef SER_FRAME_GAP_EN
    logic [1:0] r_gap_cnt;
`endif

    logic [1:0] w_arb_gnt;
    logic       w_xfer;
    logic [3:0] w_nib;

    // Round-robin pick. The pointer only matters when both requesters ask.
    always_comb begin
        w_arb_gnt = 2'b00;
        case (req)
            2'b01:   w_arb_gnt = 2'b01;
            2'b10:   w_arb_gnt = 2'b10;
            2'b11:   w_arb_gnt = r_ptr ? 2'b10 : 2'b01;
            default: w_arb_gnt = 2'b00;
        endcase
    end

    assign rdy    = (r_state == S_LOAD) ? r_gnt : 2'b00;
    assign w_xfer = |(vld & rdy);
    assign w_nib  = r_gnt[1] ? nib1 : nib0;

    assign gnt     = r_gnt;
    assign ld_en   = r_ld_en;
    assign ld_idx  = r_ld_idx;
    assign ld_data = r_ld_data;
    assign sh_en   = r_sh_en;
    assign sh_idx  = r_sh_idx;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_ld_cnt  <= 4'd0;
            r_gnt     <= 2'b00;
            r_ld_en   <= 1'b0;
            r_ld_idx  <= 4'd0;
            r_ld_data <= 4'd0;
            r_sh_en   <= 1'b0;
            r_sh_idx  <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SER_FRAME_GAP_EN
            r_gap_cnt <= 2'd0;
`endif
        end else begin
            // Strobes default low; ld_idx/ld_data hold their last value.
            r_ld_en <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_arb_gnt;
                        // Point at whichever requester was not just served.
                        r_ptr   <= w_arb_gnt[0];
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_xfer) begin
                        r_ld_en   <= 1'b1;
                        r_ld_idx  <= r_ld_cnt;
                        r_ld_data <= w_nib;
                        r_ld_cnt  <= r_ld_cnt + 4'd1;   // wraps to 0 after slot 15
                        if (r_ld_cnt == 4'd15) begin
                            r_sh_en  <= 1'b1;
                            r_sh_idx <= 6'd0;
                            r_state  <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    if (r_sh_idx == 6'd63) begin
                        r_sh_en  <= 1'b0;
                        r_sh_idx <= 6'd0;
                        r_gnt    <= 2'b00;
`ifdef SER_FRAME_GAP_EN
                        r_gap_cnt <= 2'd0;
                        r_state   <= S_GAP;
`else
                        // The frame-end edge is also the first IDLE edge, so
                        // pending requests are arbitrated here directly.
                        if (|req) begin
                            r_gnt   <= w_arb_gnt;
                            r_ptr   <= w_arb_gnt[0];
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`endif
                    end else begin
                        r_sh_idx <= r_sh_idx + 6'd1;
                        // done is registered, so raise it as sh_idx becomes 63.
                        r_done   <= (r_sh_idx == 6'd62);
                    end
                end

`ifdef SER_FRAME_GAP_EN
                S_GAP: begin
                    if (r_gap_cnt == 2'd3) begin
                        // The last gap edge doubles as the first IDLE edge.
                        if (|req) begin
                            r_gnt   <= w_arb_gnt;
                            r_ptr   <= w_arb_gnt[0];
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                        r_gap_cnt <= 2'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 2'd1;
                    end
                end
`endif

                default: begin
                    r_gnt   <= 2'b00;
                    r_sh_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
